// File: rtl/whack_pkg.sv
// Shared constants, FSM state type and hole-index helpers for the whack-a-mole datapath.
package whack_pkg;

    localparam int         NUM_HOLES  = 9;
    localparam logic [3:0] POS_NONE   = 4'd0;
    localparam logic [3:0] POS_MAX    = 4'd9;
    localparam logic [3:0] HOLE_FIRST = 4'd0;
    localparam logic [3:0] HOLE_LAST  = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SEARCH = 2'd2
    } state_e;

    // Folds a raw 4-bit value 0..15 onto a hole index 0..8.
    function automatic logic [3:0] hole_wrap(input logic [3:0] v);
        hole_wrap = (v > HOLE_LAST) ? (v - 4'd9) : v;
    endfunction

    function automatic logic [3:0] hole_next(input logic [3:0] h);
        hole_next = (h == HOLE_LAST) ? HOLE_FIRST : (h + 4'd1);
    endfunction

    function automatic logic [3:0] popcount9(input logic [NUM_HOLES-1:0] m);
        popcount9 = 4'd0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            popcount9 = popcount9 + {3'd0, m[i]};
        end
    endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side bus of the mole scheduler: run enable, struck hole, mole map and scoring pulses.
interface mole_scheduler_if;
    import whack_pkg::*;

    logic                 en;
    logic [3:0]           one_pulse_pos;
    logic [NUM_HOLES-1:0] map;
    logic                 hit_ok;
    logic                 whiff;
    logic                 miss;
    logic [3:0]           active_cnt;

    modport master (
        output en, one_pulse_pos,
        input  map, hit_ok, whiff, miss, active_cnt
    );

    modport slave (
        input  en, one_pulse_pos,
        output map, hit_ok, whiff, miss, active_cnt
    );
endinterface

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used to pick spawn candidates.
module mole_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right, feedback enters at the top bit.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // LFSR state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;
endmodule

// File: rtl/mole_scheduler.sv
// Mole appearance sequencer: spawns moles at LFSR-chosen free holes, ages them per tick,
// and resolves strikes into hit/whiff pulses and timeouts into a miss pulse.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 10_000_000,
    parameter int unsigned LIFE_TICKS  = 8,
    parameter int unsigned SPAWN_TICKS = 3,
    parameter int unsigned MAX_ACTIVE  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic              clk,
    input logic              rst,
    mole_scheduler_if.slave  bus
);
    localparam int             DIV_W      = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]     LIFE_INIT  = 4'(LIFE_TICKS);
    localparam logic [4:0]     SPAWN_LAST = 5'(SPAWN_TICKS);
    localparam logic [3:0]     MAX_ACT    = 4'(MAX_ACTIVE);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [3:0]           spawn_q, spawn_d;
    logic [3:0]           cand_q, cand_d;
    logic [3:0]           life_q [NUM_HOLES];
    logic [3:0]           life_d [NUM_HOLES];
    logic [NUM_HOLES-1:0] map_q, map_d;
    logic                 hit_ok_q, hit_ok_d;
    logic                 whiff_q, whiff_d;
    logic                 miss_q, miss_d;
    logic [3:0]           cnt_q, cnt_d;

    logic                 tick_s;
    logic [NUM_HOLES-1:0] hit_vec_s;
    logic [NUM_HOLES-1:0] exp_vec_s;
    logic [4:0]           spawn_inc_s;
    logic [3:0]           hole_s;
    logic [15:0]          lfsr_s;
    logic                 lfsr_unused_s;

    mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:4];
    assign hole_s        = bus.one_pulse_pos - 4'd1;

    // Next-state, aging, strike resolution and spawn search.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        spawn_d     = spawn_q;
        cand_d      = cand_q;
        life_d      = life_q;
        map_d       = map_q;
        hit_ok_d    = 1'b0;
        whiff_d     = 1'b0;
        miss_d      = 1'b0;
        tick_s      = 1'b0;
        hit_vec_s   = '0;
        exp_vec_s   = '0;
        spawn_inc_s = 5'd0;

        case (state_q)
            RUN, SEARCH: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    div_d   = '0;
                    spawn_d = 4'd0;
                    cand_d  = HOLE_FIRST;
                    map_d   = '0;
                    for (int i = 0; i < NUM_HOLES; i++) life_d[i] = 4'd0;
                end else begin
                    tick_s = (div_q == DIV_LAST);
                    div_d  = tick_s ? '0 : (div_q + DIV_W'(1));

                    for (int i = 0; i < NUM_HOLES; i++) begin
                        if (tick_s && map_q[i]) begin
                            life_d[i]    = life_q[i] - 4'd1;
                            exp_vec_s[i] = (life_q[i] == 4'd1);
                        end else begin
                            life_d[i] = life_q[i];
                        end
                    end

                    if ((bus.one_pulse_pos != POS_NONE) && (bus.one_pulse_pos <= POS_MAX)) begin
                        if (map_q[hole_s]) begin
                            hit_vec_s[hole_s] = 1'b1;
                            hit_ok_d          = 1'b1;
                        end else begin
                            whiff_d = 1'b1;
                        end
                    end else begin
                        hit_ok_d = 1'b0;
                    end

                    // A hit on an expiring hole scores as a hit, never as a miss.
                    map_d       = map_q & ~hit_vec_s & ~exp_vec_s;
                    miss_d      = |(exp_vec_s & ~hit_vec_s);
                    spawn_inc_s = {1'b0, spawn_q} + {4'd0, tick_s};

                    if (state_q == RUN) begin
                        if (spawn_inc_s >= SPAWN_LAST) begin
                            spawn_d = 4'd0;
                            if (cnt_q < MAX_ACT) begin
                                cand_d  = hole_wrap(lfsr_s[3:0]);
                                state_d = SEARCH;
                            end else begin
                                state_d = RUN;
                            end
                        end else begin
                            spawn_d = spawn_inc_s[3:0];
                        end
                    end else begin
                        // Ticks during a search are kept, capped at one pending attempt.
                        spawn_d = (spawn_inc_s >= SPAWN_LAST) ? SPAWN_LAST[3:0] : spawn_inc_s[3:0];
                        if (!map_q[cand_q]) begin
                            map_d[cand_q]  = 1'b1;
                            life_d[cand_q] = LIFE_INIT;
                            state_d        = RUN;
                        end else begin
                            cand_d = hole_next(cand_q);
                        end
                    end
                end
            end
            default: begin
                div_d   = '0;
                spawn_d = 4'd0;
                cand_d  = HOLE_FIRST;
                map_d   = '0;
                for (int i = 0; i < NUM_HOLES; i++) life_d[i] = 4'd0;
                state_d = bus.en ? RUN : IDLE;
            end
        endcase

        cnt_d = popcount9(map_d);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            spawn_q  <= 4'd0;
            cand_q   <= HOLE_FIRST;
            map_q    <= '0;
            hit_ok_q <= 1'b0;
            whiff_q  <= 1'b0;
            miss_q   <= 1'b0;
            cnt_q    <= 4'd0;
            for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= 4'd0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            spawn_q  <= spawn_d;
            cand_q   <= cand_d;
            map_q    <= map_d;
            hit_ok_q <= hit_ok_d;
            whiff_q  <= whiff_d;
            miss_q   <= miss_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= life_d[i];
        end
    end

    assign bus.map        = map_q;
    assign bus.hit_ok     = hit_ok_q;
    assign bus.whiff      = whiff_q;
    assign bus.miss       = miss_q;
    assign bus.active_cnt = cnt_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler, checked every cycle against a behavioural game model.
module tb_mole_scheduler;
    localparam int TICK_DIV = 4;
    localparam int LIFE_T   = 3;
    localparam int SPAWN_T  = 2;
    localparam int MAX_A    = 2;
    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_SEARCH = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    mole_scheduler_if bus_if ();

    mole_scheduler #(
        .TICK_DIV    (TICK_DIV),
        .LIFE_TICKS  (LIFE_T),
        .SPAWN_TICKS (SPAWN_T),
        .MAX_ACTIVE  (MAX_A),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Game model: holes, lives, phase, counters and the random source.
    int          m_state;
    int          m_div;
    int          m_spawn;
    int          m_cand;
    int          m_life [9];
    logic [8:0]  m_map;
    logic        m_hit, m_whiff, m_miss;
    logic [15:0] m_lfsr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_div = 0; m_spawn = 0; m_cand = 0;
        m_map = '0; m_hit = 1'b0; m_whiff = 1'b0; m_miss = 1'b0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 9; i++) m_life[i] = 0;
    endtask

    task automatic model_step(input bit en_i, input int pos_i);
        bit         tick;
        logic [8:0] old_map, exp_v, hit_v;
        int         sp;
        old_map = m_map;
        m_hit = 1'b0; m_whiff = 1'b0; m_miss = 1'b0;
        if (m_state == S_IDLE || !en_i) begin
            m_state = (m_state == S_IDLE && en_i) ? S_RUN : S_IDLE;
            m_map = '0; m_div = 0; m_spawn = 0; m_cand = 0;
            for (int i = 0; i < 9; i++) m_life[i] = 0;
        end else begin
            tick  = (m_div == TICK_DIV - 1);
            m_div = tick ? 0 : m_div + 1;
            exp_v = '0; hit_v = '0;
            for (int i = 0; i < 9; i++) begin
                if (old_map[i] && tick) begin
                    m_life[i]--;
                    if (m_life[i] == 0) exp_v[i] = 1'b1;
                end
            end
            if (pos_i >= 1 && pos_i <= 9) begin
                if (old_map[pos_i-1]) begin hit_v[pos_i-1] = 1'b1; m_hit = 1'b1; end
                else m_whiff = 1'b1;
            end
            m_map  = old_map & ~exp_v & ~hit_v;
            m_miss = |(exp_v & ~hit_v);
            sp = m_spawn + int'(tick);
            if (m_state == S_RUN) begin
                if (sp >= SPAWN_T) begin
                    m_spawn = 0;
                    if ($countones(old_map) < MAX_A) begin
                        m_cand  = int'(m_lfsr[3:0]) % 9;
                        m_state = S_SEARCH;
                    end
                end else m_spawn = sp;
            end else begin
                m_spawn = (sp > SPAWN_T) ? SPAWN_T : sp;
                if (!old_map[m_cand]) begin
                    m_map[m_cand]  = 1'b1;
                    m_life[m_cand] = LIFE_T;
                    m_state        = S_RUN;
                end else m_cand = (m_cand + 1) % 9;
            end
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    endtask

    task automatic compare_all();
        check_val("map",        32'(bus_if.map),        32'(m_map));
        check_val("hit_ok",     32'(bus_if.hit_ok),     32'(m_hit));
        check_val("whiff",      32'(bus_if.whiff),      32'(m_whiff));
        check_val("miss",       32'(bus_if.miss),       32'(m_miss));
        check_val("active_cnt", 32'(bus_if.active_cnt), 32'($countones(m_map)));
        check_val("max_active", 32'(bus_if.active_cnt <= 4'(MAX_A)), 32'd1);
    endtask

    // Drive one cycle of inputs at a falling edge, advance the model, compare at the next one.
    task automatic step(input bit en_i, input int pos_i);
        bus_if.en            = en_i;
        bus_if.one_pulse_pos = 4'(pos_i);
        model_step(en_i, pos_i);
        @(negedge clk);
        compare_all();
    endtask

    function automatic int pick_pos();
        int r, ups[$];
        r = $urandom_range(0, 99);
        for (int i = 0; i < 9; i++) if (m_map[i]) ups.push_back(i);
        if (r < 55) return 0;
        if (r < 75 && ups.size() > 0) return ups[$urandom_range(0, ups.size() - 1)] + 1;
        if (r < 85) begin
            for (int i = 0; i < 9; i++)
                if (m_map[i] && m_life[i] == 1 && m_div == TICK_DIV - 1 && m_state != S_IDLE)
                    return i + 1;
            return $urandom_range(1, 9);
        end
        return $urandom_range(0, 15);
    endfunction

    initial begin
        int misses;
        int waited;
        bus_if.en = 1'b0;
        bus_if.one_pulse_pos = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b1;

        // First spawn lands exactly two ticks after RUN plus the search cycle.
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 0);
            if (c == 9)  check_val("first_spawn_early", 32'(bus_if.active_cnt), 32'd0);
            if (c == 10) check_val("first_spawn_cnt",   32'(bus_if.active_cnt), 32'd1);
        end
        misses = 0;
        for (int c = 11; c <= 24; c++) begin
            step(1'b1, 0);
            misses += int'(bus_if.miss);
        end
        check_val("first_timeout_misses", 32'(misses), 32'd1);

        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                #2 rst = 1'b0;
                #1;
                check_val("async_rst_map",   32'(bus_if.map),        32'd0);
                check_val("async_rst_cnt",   32'(bus_if.active_cnt), 32'd0);
                check_val("async_rst_pulse", 32'({bus_if.hit_ok, bus_if.whiff, bus_if.miss}), 32'd0);
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            step($urandom_range(0, 99) != 0, pick_pos());
        end

        // Drop enable while a search is in flight.
        waited = 0;
        while (m_state != S_SEARCH && waited < 300) begin
            step(1'b1, 0);
            waited++;
        end
        check_val("search_reached", 32'(m_state == S_SEARCH), 32'd1);
        step(1'b0, 0);
        check_val("en_drop_map", 32'(bus_if.map), 32'd0);
        for (int c = 0; c < 12; c++) step(1'b0, $urandom_range(1, 9));
        check_val("idle_map", 32'(bus_if.map), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
